// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC and presenting fetched words to decode.
//   clk/reset      : clock, asynchronous active-low reset
//   pc, inst       : memory address out, instruction word back one cycle later
//   ir/ir_pc/ir_valid/ir_ready : instruction register and its decode handshake
//   branch_en/branch_target    : redirect from execute
//   halt/halted    : stop request and sticky halted status
//   fetch_count    : saturating count of instructions captured into ir
module fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);
  typedef enum logic [1:0] {START, FETCH, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, ir_pc_n;
  logic [DATA_W-1:0] ir_n;
  logic ir_valid_n, halted_n;
  logic [CNT_W-1:0] fetch_count_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= START;
      pc <= RESET_PC;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      ir_pc <= ir_pc_n;
      ir_valid <= ir_valid_n;
      halted <= halted_n;
      fetch_count <= fetch_count_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    ir_pc_n = ir_pc;
    ir_valid_n = ir_valid;
    halted_n = halted;
    fetch_count_n = fetch_count;
    case (state)
      START: begin
        // Bubble cycle: memory has not yet latched a pc, so nothing is captured.
        state_n = halt ? HALT : FETCH;
        halted_n = halt;
        pc_n = (!halt && branch_en) ? branch_target : pc;
      end
      FETCH: begin
        if (halt) begin
          state_n = HALT;
          halted_n = 1'b1;
          ir_valid_n = 1'b0;
        end else if (branch_en) begin
          // Drop the younger instruction; the target word arrives next cycle.
          pc_n = branch_target;
          ir_valid_n = 1'b0;
        end else if (!ir_valid || ir_ready) begin
          ir_n = inst;
          ir_pc_n = pc;
          ir_valid_n = 1'b1;
          pc_n = pc + 1'b1;
          fetch_count_n = &fetch_count ? fetch_count : fetch_count + 1'b1;
        end
      end
      default: begin
        halted_n = 1'b1;
        ir_valid_n = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a falling-edge-MAR memory model.
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int DW = 20;
  localparam int CW = 4;
  logic clk = 0;
  logic reset = 1;
  logic [DW-1:0] inst;
  logic [AW-1:0] pc, ir_pc, branch_target = '0;
  logic [DW-1:0] ir;
  logic ir_valid, halted;
  logic ir_ready = 1, branch_en = 0, halt = 0;
  logic [CW-1:0] fetch_count;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] mar;
  int tests = 0;
  int fails = 0;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .inst(inst), .pc(pc), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .branch_en(branch_en),
    .branch_target(branch_target), .halt(halt), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) mar <= pc;
  assign inst = mem[mar];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    ir_ready = 1;
    branch_en = 0;
    halt = 0;
    branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    #3 reset = 0;
    #1;
    tests++; if (pc !== 10'h000) begin fails++; $display("FAIL reset_pc got %h exp 000", pc); end
    tests++; if (ir !== 20'h0 || ir_pc !== 10'h0) begin fails++; $display("FAIL reset_ir got %h/%h exp 0/0", ir, ir_pc); end
    tests++; if (ir_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 4'd0) begin fails++; $display("FAIL reset_flags got v=%b h=%b c=%0d exp 0/0/0", ir_valid, halted, fetch_count); end
  endtask

  task automatic test_stream();
    do_reset();
    tick();
    tests++; if (ir_valid !== 1'b0 || pc !== 10'h000) begin fails++; $display("FAIL stream_bubble got v=%b pc=%h exp 0/000", ir_valid, pc); end
    tick();
    tests++; if (ir_valid !== 1'b1 || ir !== 20'h00001 || ir_pc !== 10'h000 || pc !== 10'h001) begin fails++; $display("FAIL stream_first got v=%b ir=%h irpc=%h pc=%h exp 1/00001/000/001", ir_valid, ir, ir_pc, pc); end
    tick();
    tests++; if (ir !== 20'h00002 || ir_pc !== 10'h001) begin fails++; $display("FAIL stream_second got ir=%h irpc=%h exp 00002/001", ir, ir_pc); end
    tick();
    tests++; if (ir !== 20'h00003 || ir_pc !== 10'h002 || fetch_count !== 4'd3) begin fails++; $display("FAIL stream_third got ir=%h irpc=%h cnt=%0d exp 00003/002/3", ir, ir_pc, fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) tick();
    ir_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (ir !== 20'h00002 || ir_pc !== 10'h001 || pc !== 10'h002 || ir_valid !== 1'b1 || fetch_count !== 4'd2) begin fails++; $display("FAIL stall_hold%0d got ir=%h irpc=%h pc=%h v=%b cnt=%0d exp 00002/001/002/1/2", i, ir, ir_pc, pc, ir_valid, fetch_count); end
    end
    ir_ready = 1;
    tick();
    tests++; if (ir !== 20'h00003 || ir_pc !== 10'h002 || pc !== 10'h003) begin fails++; $display("FAIL stall_resume got ir=%h irpc=%h pc=%h exp 00003/002/003", ir, ir_pc, pc); end
  endtask

  task automatic test_branch();
    branch_en = 1;
    branch_target = 10'h100;
    tick();
    tests++; if (ir_valid !== 1'b0 || pc !== 10'h100) begin fails++; $display("FAIL branch_flush got v=%b pc=%h exp 0/100", ir_valid, pc); end
    branch_en = 0;
    tick();
    tests++; if (ir_valid !== 1'b1 || ir_pc !== 10'h100 || ir !== 20'hA0100 || pc !== 10'h101) begin fails++; $display("FAIL branch_target got v=%b irpc=%h ir=%h pc=%h exp 1/100/A0100/101", ir_valid, ir_pc, ir, pc); end
  endtask

  task automatic test_halt();
    halt = 1;
    branch_en = 1;
    branch_target = 10'h200;
    tick();
    tests++; if (halted !== 1'b1 || ir_valid !== 1'b0 || pc !== 10'h101) begin fails++; $display("FAIL halt_enter got h=%b v=%b pc=%h exp 1/0/101", halted, ir_valid, pc); end
    halt = 0;
    ir_ready = 1;
    repeat (3) tick();
    tests++; if (halted !== 1'b1 || ir_valid !== 1'b0 || pc !== 10'h101 || ir !== 20'hA0100 || fetch_count !== 4'd4) begin fails++; $display("FAIL halt_frozen got h=%b v=%b pc=%h ir=%h cnt=%0d exp 1/0/101/A0100/4", halted, ir_valid, pc, ir, fetch_count); end
    branch_en = 0;
  endtask

  task automatic test_start_halt();
    do_reset();
    halt = 1;
    tick();
    halt = 0;
    tick();
    tests++; if (halted !== 1'b1 || ir_valid !== 1'b0 || pc !== 10'h000) begin fails++; $display("FAIL start_halt got h=%b v=%b pc=%h exp 1/0/000", halted, ir_valid, pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_en = 1;
    branch_target = 10'h3FF;
    tick();
    tests++; if (pc !== 10'h3FF || ir_valid !== 1'b0) begin fails++; $display("FAIL wrap_start_branch got pc=%h v=%b exp 3FF/0", pc, ir_valid); end
    branch_en = 0;
    tick();
    tests++; if (ir_pc !== 10'h3FF || ir !== 20'hA03FF || pc !== 10'h000) begin fails++; $display("FAIL wrap_top got irpc=%h ir=%h pc=%h exp 3FF/A03FF/000", ir_pc, ir, pc); end
    tick();
    tests++; if (ir_pc !== 10'h000 || ir !== 20'h00001 || ir_valid !== 1'b1) begin fails++; $display("FAIL wrap_zero got irpc=%h ir=%h v=%b exp 000/00001/1", ir_pc, ir, ir_valid); end
    tick();
    tests++; if (ir_pc !== 10'h001 || ir !== 20'h00002) begin fails++; $display("FAIL wrap_one got irpc=%h ir=%h exp 001/00002", ir_pc, ir); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) tick();
    ir_ready = 0;
    tick();
    tests++; if (pc !== 10'h005 || ir_pc !== 10'h004 || ir !== 20'hA0004 || ir_valid !== 1'b1) begin fails++; $display("FAIL mid_stall got pc=%h irpc=%h ir=%h v=%b exp 005/004/A0004/1", pc, ir_pc, ir, ir_valid); end
    reset = 0;
    #1;
    tests++; if (pc !== 10'h000 || ir !== 20'h0 || ir_pc !== 10'h0 || ir_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 4'd0) begin fails++; $display("FAIL mid_reset got pc=%h ir=%h irpc=%h v=%b h=%b cnt=%0d exp all 0", pc, ir, ir_pc, ir_valid, halted, fetch_count); end
    ir_ready = 1;
    reset = 1;
    tick();
    tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL mid_bubble got v=%b exp 0", ir_valid); end
    tick();
    tests++; if (ir_valid !== 1'b1 || ir !== 20'h00001 || ir_pc !== 10'h000) begin fails++; $display("FAIL mid_restart got v=%b ir=%h irpc=%h exp 1/00001/000", ir_valid, ir, ir_pc); end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (20) tick();
    tests++; if (fetch_count !== 4'd15) begin fails++; $display("FAIL count_saturate got %0d exp 15", fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 20'hA0000 ^ DW'(i);
    mem[0] = 20'h00001;
    mem[1] = 20'h00002;
    mem[2] = 20'h00003;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_halt();
    test_start_halt();
    test_wrap();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
